// File: rtl/csa_accum_ctrl.sv
// Multi-operand packet accumulator: folds operands into a carry-save pair,
// then ripples the carries out in an iterative resolve loop.
module csa_accum_ctrl #(
  parameter  int N     = 32,
  parameter  int CNT_W = 8,
  localparam int ACC_W = N + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] MAX_OPS = '1;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   s_q, s_d;
  logic [ACC_W-1:0]   c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               overflow_q, overflow_d;

  logic [ACC_W-1:0]   x;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               hit_max;
  logic               pkt_end;

  assign in_ready = !rst && (state_q == IDLE || state_q == ACCUM);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;
  assign x        = {{CNT_W{1'b0}}, in_data};
  assign cnt_nxt  = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
  assign hit_max  = (cnt_nxt == MAX_OPS);
  assign pkt_end  = in_last || hit_max;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          s_d     = x;
          c_d     = '0;
          cnt_d   = cnt_nxt;
          ovf_d   = hit_max;
          state_d = pkt_end ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          s_d     = s_q ^ c_q ^ x;
          c_d     = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
          cnt_d   = cnt_nxt;
          ovf_d   = hit_max;
          state_d = pkt_end ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: begin
        if (c_q == '0) begin
          out_sum_d   = s_q;
          out_count_d = cnt_q;
          overflow_d  = ovf_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          s_d = s_q ^ c_q;
          c_d = (s_q & c_q) << 1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          s_d         = '0;
          c_d         = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomized bench for csa_accum_ctrl; packet sums come from plain
// integer addition over the operand queue.
module tb_csa_accum_ctrl;

  localparam int N     = 8;
  localparam int CNT_W = 4;
  localparam int ACC_W = N + CNT_W;
  localparam int MAXOP = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             overflow;
  logic             busy;

  csa_accum_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ops[$], input bit use_last,
                      input bit gaps);
    int w;
    bit rdy;
    for (int i = 0; i < ops.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data  = ops[i];
      in_last  = use_last && (i == ops.size() - 1);
      w = 0;
      forever begin
        rdy = in_ready;
        tick();
        w++;
        if (rdy) break;
        if (w > 50) begin
          chk("accept_timeout", 0, 1);
          break;
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    lat = 1;
  endtask

  task automatic get_result(input string tag, input int es,
                            input int ec, input bit eo);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_cnt"}, out_count, ec);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_rdy"}, in_ready, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, out_valid, 0);
    chk({tag, "_hs_rdy"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [ACC_W-1:0] held;
    int ref_sum;
    int len;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    q = '{8'hA5};
    send(q, 1'b1, 1'b0);
    get_result("single", 'h0A5, 1, 1'b0);
    chk("single_lat", lat, 2);
    handshake("single");

    q = '{8'hFF, 8'hFF, 8'hFF, 8'h01};
    send(q, 1'b1, 1'b0);
    get_result("b2b", 'h2FE, 4, 1'b0);
    chk("b2b_lat_bound", 32'(lat <= ACC_W + 2), 1);
    handshake("b2b");

    q = {};
    for (int i = 0; i < MAXOP; i++) q.push_back(8'hFF);
    send(q, 1'b0, 1'b0);
    chk("ovf_stop_rdy", in_ready, 0);
    get_result("ovf", 'hEF1, 15, 1'b1);
    handshake("ovf");

    q = '{8'h3C};
    send(q, 1'b1, 1'b0);
    get_result("bp", 'h03C, 1, 1'b0);
    held = out_sum;
    in_valid = 1'b1;
    in_data = 8'h77;
    in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", out_sum, held);
      chk("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_rdy", in_ready, 1);
    chk("bp_hs_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("bp_next_busy", busy, 1);
    lat = 1;
    get_result("bp_next", 'h077, 1, 1'b0);
    handshake("bp_next");

    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, MAXOP);
      q = {};
      ref_sum = 0;
      for (int i = 0; i < len; i++) begin
        q.push_back(8'($urandom));
        ref_sum += int'(q[i]);
      end
      send(q, 1'b1, 1'b1);
      get_result("rnd", ref_sum, len, len == MAXOP);
      repeat ($urandom_range(0, 2)) tick();
      handshake("rnd");
    end

    q = '{8'h80, 8'h80, 8'h80};
    send(q, 1'b1, 1'b0);
    chk("rr_in_resolve", busy, 1);
    rst = 1'b1;
    #1;
    chk("rr_rdy_in_rst", in_ready, 0);
    tick();
    chk("rr_valid", out_valid, 0);
    chk("rr_sum", out_sum, 0);
    chk("rr_cnt", out_count, 0);
    chk("rr_ovf", overflow, 0);
    chk("rr_busy", busy, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rr_no_output", out_valid, 0);
    q = '{8'h01};
    send(q, 1'b1, 1'b0);
    get_result("rr_next", 'h001, 1, 1'b0);
    handshake("rr_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csa_accum_ctrl.md
# csa_accum_ctrl

Sequential multi-operand accumulator controller built around the carry-save adder datapath. It accepts a packet of N-bit operands over a valid/ready stream and folds each operand into redundant sum/carry registers, one 3:2 compression per cycle. On the packet's last operand it resolves the redundant pair into a single binary result through an iterative carry-resolution loop, then presents the result on a valid/ready output. It sits between an operand producer and any consumer of packet sums, and it bounds carry propagation to the resolve phase only.

## Interface
- N, default 32, operand width in bits
- CNT_W, default 8, operand-counter width; a packet holds at most MAX_OPS = 2^CNT_W-1 operands
- ACC_W, derived N+CNT_W, width of the accumulator and the result; not overridable
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  operand valid
- in_ready  out  1  controller can accept an operand
- in_data  in  N  operand, unsigned
- in_last  in  1  marks the final operand of a packet; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  ACC_W  resolved packet sum
- out_count  out  CNT_W  number of operands in the packet
- overflow  out  1  packet was force-terminated at MAX_OPS; valid with out_valid
- busy  out  1  high in ACCUM, RESOLVE and DONE

## Operation
- State machine states: IDLE, ACCUM, RESOLVE, DONE. Registers: S[ACC_W], C[ACC_W], cnt[CNT_W].
- Accept condition is in_valid && in_ready. in_ready = !rst && (state==IDLE || state==ACCUM).
- IDLE, on accept: S<=zext(in_data), C<=0, cnt<=1. Next state is RESOLVE if the packet ends, else ACCUM.
- ACCUM, on accept with X=zext(in_data):
  - S<=S^C^X
  - C<=((S&C)|(S&X)|(C&X))<<1, truncated to ACC_W
  - cnt<=cnt+1
- ACCUM with no accept holds all registers.
- A packet ends on an accepted operand with in_last=1, or on the accept that makes cnt==MAX_OPS. The second case sets an internal ovf flag and ignores in_last. Next state is RESOLVE.
- RESOLVE, each cycle:
  - if C==0: out_sum<=S, out_count<=cnt, overflow<=ovf, out_valid<=1, go to DONE
  - else: S<=S^C, C<=(S&C)<<1
- RESOLVE always terminates within ACC_W iterations.
- Arithmetic rule: at every cycle S+C mod 2^ACC_W equals the true sum of accepted operands. The true sum never exceeds MAX_OPS*(2^N-1) < 2^ACC_W, so no truncation loss occurs.
- DONE holds the outputs stable. On out_ready: out_valid<=0, S,C,cnt,ovf cleared, go to IDLE.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Reset, including mid-ACCUM, mid-RESOLVE or in DONE: state<=IDLE and every register cleared. The partial packet is discarded and produces no output.

## Timing
- Reset values: in_ready 0 while rst is high, then 1 in IDLE. out_valid 0, out_sum 0, out_count 0, overflow 0, busy 0.
- Throughput is one operand per cycle with in_valid held high; there are no bubbles inside ACCUM.
- Last operand accepted at edge t: RESOLVE occupies t+1 .. t+k+1, where k is the number of nonzero-C iterations. out_valid rises at edge t+k+2.
- Minimum latency: a single-operand packet has k=0, so out_valid rises 2 cycles after accept.
- in_ready is 0 from the cycle after the last accept until the cycle after the out_valid&&out_ready handshake. The next packet's first operand can be accepted one cycle after that handshake.
- out_sum, out_count and overflow change only when entering DONE or on reset.

## Test plan
- N=8, CNT_W=4. Single operand 0xA5 with in_last -> out_sum=0x0A5, out_count=1, overflow=0, out_valid 2 cycles after accept.
- Back-to-back operands 0xFF,0xFF,0xFF,0x01 (last on 0x01) -> out_sum=0x2FE, out_count=4. RESOLVE lasts at most 12 cycles.
- Fifteen operands of 0xFF, in_last never asserted -> forced end after the 15th accept: out_sum=0xEF1, out_count=15, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored. Raise out_ready -> handshake, then the next packet's first operand is accepted one cycle later.
- Random in_valid gaps over 100 random packets, each of 1-15 operands -> every out_sum matches a reference sum and every out_count matches.
- rst pulse during RESOLVE of packet {0x80,0x80,0x80} -> all outputs at reset values, no out_valid. The following packet {0x01} gives out_sum=0x001.
